ibex_tlul_host_arb: RTL and testbench
=====================================

Name: ibex_tlul_host_arb

Overview:
- Shares a single TL-UL host port between the Ibex core's instruction-fetch and data-LSU request interfaces (req/gnt/rvalid protocol).
- Arbitrates A-channel requests and translates them to TL-UL Get/PutFullData/PutPartialData.
- Tracks outstanding transactions per requester and routes D-channel responses back by source ID.
- Sits between the core and the top-level TL-UL crossbar in single-port SoC configurations.

Parameters:
- MaxOutstanding, 2, max in-flight transactions per requester (1..4).
- RoundRobin, 1'b1: 1 = round-robin arbitration; 0 = fixed priority, data over instr.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- instr_req_i  in  1  fetch request
- instr_gnt_o  out  1  fetch request accepted
- instr_addr_i  in  32  fetch address
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- instr_err_o  out  1  fetch bus error
- data_req_i  in  1  LSU request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  LSU address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  LSU request accepted
- data_rvalid_o  out  1  LSU response valid
- data_rdata_o  out  32  LSU read data
- data_err_o  out  1  LSU bus error
- tl_a_valid_o, tl_a_ready_i, tl_a_opcode_o[2:0], tl_a_param_o[2:0], tl_a_size_o[TL_SZW], tl_a_source_o[TL_AIW], tl_a_address_o[TL_AW], tl_a_mask_o[TL_DBW], tl_a_data_o[TL_DW], tl_a_user_o (rsvd1 7b, parity_en 1b, parity 8b), tl_a_corrupt_o  TL-UL A channel
- tl_d_valid_i, tl_d_ready_o, tl_d_opcode_i[2:0], tl_d_source_i[TL_AIW], tl_d_data_i[TL_DW], tl_d_corrupt_i, tl_d_denied_i  TL-UL D channel; other D fields are ignored
- unexp_rsp_o  out  1  sticky flag: response received with no matching outstanding request

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - all counters 0, lock cleared, RR pointer = instr, unexp_rsp_o = 0.
  - All outputs are combinational from that state, so a_valid = 0, gnt = 0, rvalid = 0 while no request is pending.
- Eligibility: a requester is eligible when req_i = 1 and its outstanding count < MaxOutstanding. Eligibility uses the registered count; there is no same-cycle bypass from a D retire.
- Arbitration:
  - One eligible requester: it wins.
  - Both eligible:
    - RoundRobin = 1: the winner is the requester not granted last.
    - RoundRobin = 0: data wins.
  - The RR pointer updates only on an A handshake.
- Lock states IDLE / LOCKED:
  - IDLE: tl_a_valid_o = winner present. If a_valid & !a_ready, go to LOCKED(winner).
  - LOCKED: the selection is frozen to the locked requester, whose req/addr are held by protocol. On a_ready, return to IDLE.
  - This keeps the A payload stable until the handshake, per TL-UL.
- gnt: requester's gnt_o = tl_a_valid_o & tl_a_ready_i & selected. Same cycle as the handshake, zero added latency.
- A payload:
  - address = {addr[31:2], 2'b00}; size = 2.
  - Instr: Get (4), mask = 4'hF.
  - Data read: Get (4), mask = data_be_i.
  - Data write with be = 4'hF: PutFullData (0).
  - Data write with other be: PutPartialData (1).
  - data = wdata (0 for Get); param = 0; user fields = 0; corrupt = 0.
- Source ID: source[0] = requester (0 instr, 1 data); upper bits = 0.
- Counters:
  - Per requester, width clog2(MaxOutstanding+1).
  - +1 on that requester's A handshake; -1 on a D response with matching source[0].
  - Both in the same cycle: count unchanged.
- D channel:
  - tl_d_ready_o is constant 1.
  - On d_valid with count > 0 for source[0]: that requester's rvalid_o = 1 for one cycle, rdata = d_data, err = d_denied | d_corrupt.
  - On d_valid with count = 0: the response is dropped, no rvalid, and unexp_rsp_o is set until reset.
  - Responses are returned in order per requester; interleaving across requesters is allowed.
- Reset mid-transaction: in-flight transactions are abandoned and any late D responses raise unexp_rsp_o. Top-level sequencing holds the fabric in reset alongside this block.

Decomposition:
- Shared package ibex_tlul_arb_pkg holds:
  - requester_e {ReqInstr = 0, ReqData = 1}
  - TL opcode constants (Get = 4, PutFullData = 0, PutPartialData = 1)
  - TL_SZW / TL_AIW / TL_DW imported from top_pkg
- One natural sub-module: ibex_tlul_arb_outst_cnt, the per-requester outstanding counter with full/empty flags, instantiated twice.

Test Plan:
1. Instr req addr 0x8000_0002, a_ready = 1 → same-cycle instr_gnt_o; A = Get, address 0x8000_0000, mask 0xF, source 0. Then D source 0 with data 0x1234_5678 → instr_rvalid_o with rdata 0x1234_5678, err 0.
2. Both req every cycle, RoundRobin = 1, a_ready = 1, D responses returned promptly → grants alternate instr, data, instr, data; neither starves.
3. Data write be = 4'b0011, a_ready low 3 cycles → a_valid held with stable payload and opcode PutPartialData for all 3 cycles; gnt only on the 4th cycle.
4. MaxOutstanding = 2, instr issues 2 with no D → third request gets no gnt. D arrives and count drops to 1 → gnt on the following cycle, not the same cycle.
5. D source 1 with d_denied = 1 → data_rvalid_o with data_err_o = 1. D source 0 with zero outstanding → no rvalid and unexp_rsp_o = 1 sticky.
6. Assert rst_ni low while LOCKED with 1 outstanding → next cycle a_valid = 0, counts 0; a request after reset proceeds normally.

Source files
------------

// File: rtl/ibex_tlul_arb_pkg.sv
// Shared types and TL-UL constants for the Ibex single-port TL-UL host arbiter.
// The TL widths match the SoC top_pkg configuration.
package ibex_tlul_arb_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AUW = 16;

  typedef enum logic {
    ReqInstr = 1'b0,
    ReqData  = 1'b1
  } requester_e;

  localparam logic [2:0] OpGet            = 3'd4;
  localparam logic [2:0] OpPutFullData    = 3'd0;
  localparam logic [2:0] OpPutPartialData = 3'd1;

  localparam logic LockIdle   = 1'b0;
  localparam logic LockLocked = 1'b1;

  function automatic requester_e other_req(requester_e r);
    return (r == ReqInstr) ? ReqData : ReqInstr;
  endfunction

endpackage

// File: rtl/ibex_tlul_arb_outst_cnt.sv
// Outstanding-transaction counter for one requester, with full/empty flags.
module ibex_tlul_arb_outst_cnt
  import ibex_tlul_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [CntW-1:0] r_cnt;

  // Simultaneous issue and retire leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (inc_i && !dec_i) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (dec_i && !inc_i) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign full_o  = (r_cnt == CntW'(MaxOutstanding));
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/ibex_tlul_host_arb.sv
// Shares one TL-UL host port between the Ibex fetch and LSU interfaces:
// arbitrates A requests, holds the payload until handshake, routes D by source.
module ibex_tlul_host_arb
  import ibex_tlul_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,

  output logic              tl_a_valid_o,
  input  logic              tl_a_ready_i,
  output logic [2:0]        tl_a_opcode_o,
  output logic [2:0]        tl_a_param_o,
  output logic [TL_SZW-1:0] tl_a_size_o,
  output logic [TL_AIW-1:0] tl_a_source_o,
  output logic [TL_AW-1:0]  tl_a_address_o,
  output logic [TL_DBW-1:0] tl_a_mask_o,
  output logic [TL_DW-1:0]  tl_a_data_o,
  output logic [TL_AUW-1:0] tl_a_user_o,
  output logic              tl_a_corrupt_o,

  input  logic              tl_d_valid_i,
  output logic              tl_d_ready_o,
  input  logic [2:0]        tl_d_opcode_i,
  input  logic [TL_AIW-1:0] tl_d_source_i,
  input  logic [TL_DW-1:0]  tl_d_data_i,
  input  logic              tl_d_corrupt_i,
  input  logic              tl_d_denied_i,

  output logic              unexp_rsp_o
);

  logic       r_lock_state;
  requester_e r_lock_sel;
  requester_e r_rr_prio;
  logic       r_unexp;

  logic [1:0] w_req;
  logic [1:0] w_full;
  logic [1:0] w_empty;
  logic [1:0] w_elig;
  logic [1:0] w_inc;
  logic [1:0] w_dec;
  requester_e w_arb_sel;
  requester_e w_sel;
  logic       w_hs;
  logic       w_d_src;
  logic       w_d_hit;
  logic       w_d_unexp;
  logic       w_unused;

  assign w_req  = {data_req_i, instr_req_i};
  assign w_elig = w_req & ~w_full;

  // Index 0 is instr, index 1 is data, matching the TL source bit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    assign w_inc[gi] = w_hs && (w_sel == requester_e'(gi));
    assign w_dec[gi] = w_d_hit && (w_d_src == 1'(gi));

    ibex_tlul_arb_outst_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (w_inc[gi]),
      .dec_i  (w_dec[gi]),
      .full_o (w_full[gi]),
      .empty_o(w_empty[gi])
    );
  end

  always_comb begin
    w_arb_sel = ReqInstr;
    if (w_elig[0] && w_elig[1]) begin
      w_arb_sel = RoundRobin ? r_rr_prio : ReqData;
    end else if (w_elig[1]) begin
      w_arb_sel = ReqData;
    end
  end

  // While locked the requester holds its request, so valid stays asserted.
  assign w_sel        = (r_lock_state == LockLocked) ? r_lock_sel : w_arb_sel;
  assign tl_a_valid_o = (r_lock_state == LockLocked) || (|w_elig);
  assign w_hs         = tl_a_valid_o && tl_a_ready_i;
  assign instr_gnt_o  = w_hs && (w_sel == ReqInstr);
  assign data_gnt_o   = w_hs && (w_sel == ReqData);

  always_comb begin
    tl_a_opcode_o  = OpGet;
    tl_a_address_o = {instr_addr_i[31:2], 2'b00};
    tl_a_mask_o    = 4'hF;
    tl_a_data_o    = '0;
    if (w_sel == ReqData) begin
      tl_a_address_o = {data_addr_i[31:2], 2'b00};
      tl_a_mask_o    = data_be_i;
      if (data_we_i) begin
        tl_a_opcode_o = (data_be_i == 4'hF) ? OpPutFullData : OpPutPartialData;
        tl_a_data_o   = data_wdata_i;
      end
    end
  end

  assign tl_a_param_o   = 3'd0;
  assign tl_a_size_o    = TL_SZW'(2);
  assign tl_a_source_o  = {{(TL_AIW-1){1'b0}}, w_sel};
  assign tl_a_user_o    = '0;
  assign tl_a_corrupt_o = 1'b0;

  assign tl_d_ready_o   = 1'b1;
  assign w_d_src        = tl_d_source_i[0];
  assign w_d_hit        = tl_d_valid_i && !w_empty[w_d_src];
  assign w_d_unexp      = tl_d_valid_i && w_empty[w_d_src];

  assign instr_rvalid_o = w_d_hit && (w_d_src == 1'b0);
  assign data_rvalid_o  = w_d_hit && (w_d_src == 1'b1);
  assign instr_rdata_o  = tl_d_data_i;
  assign data_rdata_o   = tl_d_data_i;
  assign instr_err_o    = tl_d_denied_i | tl_d_corrupt_i;
  assign data_err_o     = tl_d_denied_i | tl_d_corrupt_i;
  assign unexp_rsp_o    = r_unexp;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock_state <= LockIdle;
      r_lock_sel   <= ReqInstr;
      r_rr_prio    <= ReqInstr;
      r_unexp      <= 1'b0;
    end else begin
      if (r_lock_state == LockIdle) begin
        if (tl_a_valid_o && !tl_a_ready_i) begin
          r_lock_state <= LockLocked;
          r_lock_sel   <= w_sel;
        end
      end else if (tl_a_ready_i) begin
        r_lock_state <= LockIdle;
      end
      if (w_hs) begin
        r_rr_prio <= other_req(w_sel);
      end
      if (w_d_unexp) begin
        r_unexp <= 1'b1;
      end
    end
  end

  assign w_unused = ^{tl_d_opcode_i, tl_d_source_i[TL_AIW-1:1],
                      instr_addr_i[1:0], data_addr_i[1:0]};

endmodule

// File: tb/tb_ibex_tlul_host_arb.sv
// Self-checking bench: reset-relative payload vectors, directed corner sequences,
// and a randomized run against a rule-level reference model.
module tb_ibex_tlul_host_arb;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        a_valid, a_ready, a_corrupt;
  logic [2:0]  a_opcode, a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic [15:0] a_user;
  logic        d_valid, d_ready, d_corrupt, d_denied;
  logic [2:0]  d_opcode;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        unexp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_tlul_host_arb #(.MaxOutstanding(MAXO), .RoundRobin(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .tl_a_valid_o(a_valid), .tl_a_ready_i(a_ready), .tl_a_opcode_o(a_opcode),
    .tl_a_param_o(a_param), .tl_a_size_o(a_size), .tl_a_source_o(a_source),
    .tl_a_address_o(a_address), .tl_a_mask_o(a_mask), .tl_a_data_o(a_data),
    .tl_a_user_o(a_user), .tl_a_corrupt_o(a_corrupt),
    .tl_d_valid_i(d_valid), .tl_d_ready_o(d_ready), .tl_d_opcode_i(d_opcode),
    .tl_d_source_i(d_source), .tl_d_data_i(d_data), .tl_d_corrupt_i(d_corrupt),
    .tl_d_denied_i(d_denied), .unexp_rsp_o(unexp)
  );

  typedef struct {
    logic        ireq, dreq, we;
    logic [3:0]  be;
    logic [31:0] iaddr, daddr, wdata;
    logic        ready;
    logic        exp_valid, exp_ig, exp_dg;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    logic        exp_src;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = 0;
    data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
    a_ready = 0; d_valid = 0; d_opcode = 0; d_source = 0; d_data = 0;
    d_corrupt = 0; d_denied = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic chk_payload(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] data, input logic src);
    chk({tag, ".opcode"}, 64'(a_opcode), 64'(op));
    chk({tag, ".address"}, 64'(a_address), 64'(addr));
    chk({tag, ".mask"}, 64'(a_mask), 64'(mask));
    chk({tag, ".data"}, 64'(a_data), 64'(data));
    chk({tag, ".source"}, 64'(a_source), {63'd0, src});
    chk({tag, ".fixed"}, {a_size, a_param, a_user, a_corrupt}, {2'd2, 3'd0, 16'd0, 1'b0});
  endtask

  // Reference model state: outstanding counts, lock, and who wins the next tie.
  int m_cnt[2];
  bit m_locked;
  int m_lock_who;
  int m_prio;
  bit m_unexp;

  task automatic random_run(input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      bit el0, el1, v, hit;
      int who, src;
      logic [2:0] e_op;
      if (!(m_locked && m_lock_who == 0)) begin
        instr_req  = 1'($urandom_range(0, 1));
        instr_addr = $urandom;
      end
      if (!(m_locked && m_lock_who == 1)) begin
        data_req   = 1'($urandom_range(0, 1));
        data_we    = 1'($urandom_range(0, 1));
        data_be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      a_ready   = ($urandom_range(0, 3) != 0);
      d_valid   = ($urandom_range(0, 2) == 0);
      src       = (m_cnt[1] > 0 && (m_cnt[0] == 0 || $urandom_range(0, 1) == 1)) ? 1 : 0;
      if ($urandom_range(0, 15) == 0) src = 1 - src;
      d_source  = {7'($urandom), 1'(src)};
      d_data    = $urandom;
      d_denied  = ($urandom_range(0, 7) == 0);
      d_corrupt = ($urandom_range(0, 7) == 0);

      el0 = instr_req && (m_cnt[0] < MAXO);
      el1 = data_req && (m_cnt[1] < MAXO);
      if (m_locked) begin
        v = 1; who = m_lock_who;
      end else begin
        v = el0 || el1;
        who = (el0 && el1) ? m_prio : (el1 ? 1 : 0);
      end
      hit = d_valid && (m_cnt[src] > 0);

      @(negedge clk);
      chk("rnd.a_valid", 64'(a_valid), 64'(v));
      chk("rnd.instr_gnt", 64'(instr_gnt), 64'(v && a_ready && who == 0));
      chk("rnd.data_gnt", 64'(data_gnt), 64'(v && a_ready && who == 1));
      if (v) begin
        if (who == 0) begin
          chk_payload("rnd.i", 3'd4, instr_addr & 32'hFFFF_FFFC, 4'hF, 32'd0, 1'b0);
        end else begin
          e_op = !data_we ? 3'd4 : (data_be == 4'hF ? 3'd0 : 3'd1);
          chk_payload("rnd.d", e_op, data_addr & 32'hFFFF_FFFC, data_be,
                      data_we ? data_wdata : 32'd0, 1'b1);
        end
      end
      chk("rnd.instr_rvalid", 64'(instr_rvalid), 64'(hit && src == 0));
      chk("rnd.data_rvalid", 64'(data_rvalid), 64'(hit && src == 1));
      if (hit) begin
        chk("rnd.rdata", 64'(src == 0 ? instr_rdata : data_rdata), 64'(d_data));
        chk("rnd.err", 64'(src == 0 ? instr_err : data_err), 64'(d_denied | d_corrupt));
      end
      chk("rnd.unexp", 64'(unexp), 64'(m_unexp));
      chk("rnd.d_ready", 64'(d_ready), 64'd1);

      if (v && a_ready) $display("txn A req=%0d addr=%08h", who, who ? data_addr : instr_addr);
      if (d_valid) $display("txn D src=%0d hit=%0d data=%08h", src, hit, d_data);
      if (v && a_ready) begin
        m_cnt[who]++;
        m_prio = 1 - who;
      end
      if (hit) m_cnt[src]--;
      if (d_valid && !hit) m_unexp = 1;
      if (!m_locked && v && !a_ready) begin
        m_locked = 1; m_lock_who = who;
      end else if (m_locked && a_ready) begin
        m_locked = 0;
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    vecs[0] = '{1, 0, 0, 4'h0, 32'h8000_0002, 32'h0, 32'h0, 1,
                1, 1, 0, 3'd4, 32'h8000_0000, 4'hF, 32'h0, 0};
    vecs[1] = '{0, 1, 0, 4'h5, 32'h0, 32'h1000_0007, 32'h0000_DEAD, 1,
                1, 0, 1, 3'd4, 32'h1000_0004, 4'h5, 32'h0, 1};
    vecs[2] = '{0, 1, 1, 4'hF, 32'h0, 32'h2000_0000, 32'hCAFE_BABE, 1,
                1, 0, 1, 3'd0, 32'h2000_0000, 4'hF, 32'hCAFE_BABE, 1};
    vecs[3] = '{0, 1, 1, 4'h3, 32'h0, 32'h2000_0013, 32'h1122_3344, 1,
                1, 0, 1, 3'd1, 32'h2000_0010, 4'h3, 32'h1122_3344, 1};
    vecs[4] = '{1, 1, 1, 4'hF, 32'h0000_0004, 32'h0000_0008, 32'h5555_5555, 1,
                1, 1, 0, 3'd4, 32'h0000_0004, 4'hF, 32'h0, 0};
    vecs[5] = '{0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1,
                0, 0, 0, 3'd0, 32'h0, 4'h0, 32'h0, 0};
    vecs[6] = '{1, 0, 0, 4'h0, 32'h0000_0100, 32'h0, 32'h0, 0,
                1, 0, 0, 3'd4, 32'h0000_0100, 4'hF, 32'h0, 0};

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst.a_valid", 64'(a_valid), 64'd0);
    chk("rst.gnt", {instr_gnt, data_gnt}, 64'd0);
    chk("rst.rvalid", {instr_rvalid, data_rvalid}, 64'd0);
    chk("rst.unexp", 64'(unexp), 64'd0);
    chk("rst.d_ready", 64'(d_ready), 64'd1);

    // Single-cycle vectors, each from a fresh reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      instr_req = vecs[i].ireq; data_req = vecs[i].dreq; data_we = vecs[i].we;
      data_be = vecs[i].be; instr_addr = vecs[i].iaddr; data_addr = vecs[i].daddr;
      data_wdata = vecs[i].wdata; a_ready = vecs[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d.a_valid", i), 64'(a_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.instr_gnt", i), 64'(instr_gnt), 64'(vecs[i].exp_ig));
      chk($sformatf("vec%0d.data_gnt", i), 64'(data_gnt), 64'(vecs[i].exp_dg));
      if (vecs[i].exp_valid)
        chk_payload($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_addr,
                    vecs[i].exp_mask, vecs[i].exp_data, vecs[i].exp_src);
      $display("txn vec%0d valid=%0b op=%0d addr=%08h", i, a_valid, a_opcode, a_address);
      tick();
    end

    // Fetch then its response.
    do_reset();
    instr_req = 1; instr_addr = 32'h8000_0002; a_ready = 1;
    @(negedge clk);
    chk("seq1.gnt", 64'(instr_gnt), 64'd1);
    chk_payload("seq1", 3'd4, 32'h8000_0000, 4'hF, 32'd0, 1'b0);
    tick();
    instr_req = 0; d_valid = 1; d_source = 8'h00; d_data = 32'h1234_5678;
    @(negedge clk);
    chk("seq1.rvalid", {instr_rvalid, data_rvalid}, 64'b10);
    chk("seq1.rdata", 64'(instr_rdata), 64'h1234_5678);
    chk("seq1.err", 64'(instr_err), 64'd0);
    $display("txn seq1 D rdata=%08h", instr_rdata);
    tick();

    // Round robin with both requesting continuously.
    do_reset();
    instr_req = 1; data_req = 1; a_ready = 1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        d_valid = 1; d_source = {7'd0, 1'((k - 1) % 2)}; d_data = 32'(k);
      end
      @(negedge clk);
      chk($sformatf("seq2.instr_gnt%0d", k), 64'(instr_gnt), 64'(k % 2 == 0));
      chk($sformatf("seq2.data_gnt%0d", k), 64'(data_gnt), 64'(k % 2 == 1));
      $display("txn seq2 cycle%0d igt=%0b dgt=%0b", k, instr_gnt, data_gnt);
      tick();
    end

    // Stalled partial write keeps its payload; a later fetch request cannot steal the slot.
    do_reset();
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h3000_0006;
    data_wdata = 32'hA5A5_0F0F; a_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin instr_req = 1; instr_addr = 32'h0000_0040; end
      if (k == 3) a_ready = 1;
      @(negedge clk);
      chk($sformatf("seq3.a_valid%0d", k), 64'(a_valid), 64'd1);
      chk_payload($sformatf("seq3.c%0d", k), 3'd1, 32'h3000_0004, 4'b0011, 32'hA5A5_0F0F, 1'b1);
      chk($sformatf("seq3.gnt%0d", k), {instr_gnt, data_gnt}, (k == 3) ? 64'b01 : 64'b00);
      tick();
    end
    $display("txn seq3 partial write granted after stall");

    // Outstanding limit; a retire frees the slot only from the next cycle.
    do_reset();
    instr_req = 1; instr_addr = 32'h0000_1000; a_ready = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("seq4.gnt%0d", k), 64'(instr_gnt), 64'd1);
      tick();
    end
    d_valid = 1; d_source = 8'h00; d_data = 32'h0BAD_F00D;
    @(negedge clk);
    chk("seq4.full_gnt", 64'(instr_gnt), 64'd0);
    chk("seq4.full_valid", 64'(a_valid), 64'd0);
    chk("seq4.retire", 64'(instr_rvalid), 64'd1);
    tick();
    d_valid = 0;
    @(negedge clk);
    chk("seq4.after_retire_gnt", 64'(instr_gnt), 64'd1);
    $display("txn seq4 limit honoured");
    tick();

    // Denied data response, then an unexpected fetch response.
    do_reset();
    data_req = 1; data_addr = 32'h4000_0000; data_be = 4'hF; a_ready = 1;
    @(negedge clk);
    chk("seq5.gnt", 64'(data_gnt), 64'd1);
    tick();
    data_req = 0; d_valid = 1; d_source = 8'h01; d_denied = 1; d_data = 32'h0;
    @(negedge clk);
    chk("seq5.rvalid", {instr_rvalid, data_rvalid}, 64'b01);
    chk("seq5.err", 64'(data_err), 64'd1);
    tick();
    d_source = 8'h00; d_denied = 0;
    @(negedge clk);
    chk("seq5.unexp_rvalid", {instr_rvalid, data_rvalid}, 64'b00);
    tick();
    d_valid = 0;
    @(negedge clk);
    chk("seq5.unexp_set", 64'(unexp), 64'd1);
    tick();
    @(negedge clk);
    chk("seq5.unexp_sticky", 64'(unexp), 64'd1);
    tick();

    // Reset while locked with one data transaction outstanding.
    do_reset();
    data_req = 1; data_addr = 32'h5000_0000; data_be = 4'hF; a_ready = 1;
    @(negedge clk);
    chk("seq6.pre_gnt", 64'(data_gnt), 64'd1);
    tick();
    data_req = 0; instr_req = 1; instr_addr = 32'h0000_2000; a_ready = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; instr_req = 0;
    @(negedge clk);
    chk("seq6.a_valid", 64'(a_valid), 64'd0);
    chk("seq6.unexp", 64'(unexp), 64'd0);
    tick();
    d_valid = 1; d_source = 8'h01;
    @(negedge clk);
    chk("seq6.late_rvalid", 64'(data_rvalid), 64'd0);
    tick();
    d_valid = 0; data_req = 1; a_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) chk("seq6.late_unexp", 64'(unexp), 64'd1);
      chk($sformatf("seq6.post_gnt%0d", k), {instr_gnt, data_gnt}, (k < 2) ? 64'b01 : 64'b00);
      if (k == 0) chk("seq6.source", 64'(a_source), 64'd1);
      tick();
    end
    $display("txn seq6 recovered after reset");

    // Randomized run against the reference model.
    do_reset();
    m_cnt[0] = 0; m_cnt[1] = 0; m_locked = 0; m_lock_who = 0; m_prio = 0; m_unexp = 0;
    random_run(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
